mm_display_scheduler: RTL and testbench
=======================================

# mm_display_scheduler

Sequencer that owns the four-digit seven-segment display path of the Mastermind game and shares it between two sources: the guess editor (four 3-bit colour codes plus a cursor) and the scoring unit (exact/partial peg counts). It produces the four 3-bit digit codes consumed by `seven_segment` plus a per-digit blank mask applied at top level. It also sequences the visual behaviour: cursor blink while editing, timed feedback display after each scored guess, and a flashing win display until a new game starts.

## Interface
- `BLINK_DIV`, 25_000_000: clock cycles per blink half-period; must be ≥2.
- `SHOW_CYCLES`, 100_000_000: clock cycles feedback stays on the display; must be ≥2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `guess_d0`..`guess_d3`  in  3 each  current guess colour codes from the editor.
- `cursor`  in  2  index (0..3) of the digit being edited.
- `edit_en`  in  1  1 enables cursor blink in EDIT.
- `fb_valid`  in  1  scoring unit offers feedback.
- `fb_exact`  in  3  exact-match count, 0..4.
- `fb_partial`  in  3  colour-only match count, 0..4.
- `fb_ready`  out  1  scheduler accepts feedback this cycle.
- `new_game`  in  1  single-cycle pulse that returns the scheduler to EDIT.
- `d0`..`d3`  out  3 each  digit codes to `seven_segment`.
- `blank`  out  4  bit i = 1 forces HEXi dark at top level.
- `showing_fb`  out  1  1 while FEEDBACK is displayed.
- `win`  out  1  1 in WIN.

## Operation
- States: EDIT, FEEDBACK, WIN. The reset state is EDIT.
- Handshake: `fb_ready` = (state==EDIT) && !`new_game`, combinational.
  - Feedback is accepted on a rising edge where `fb_valid` && `fb_ready`.
  - On acceptance, `fb_exact` and `fb_partial` are latched.
  - `fb_valid` is ignored in FEEDBACK and WIN.
- EDIT → FEEDBACK on acceptance when latched exact ≠ 4.
- EDIT → WIN on acceptance when latched exact == 4.
- FEEDBACK → EDIT after SHOW_CYCLES cycles in FEEDBACK.
- WIN is held until `new_game`.
- `new_game` forces EDIT from any state. It has priority over acceptance and over the FEEDBACK timeout.
- Display content:
  - EDIT: `d`i = `guess_d`i. `blank[cursor]` = `edit_en` && !phase; all other blank bits are 0.
  - FEEDBACK: `d3` = exact, `d2` = partial, `d1` = `d0` = 0, `blank` = 4'b0011.
  - WIN: `d`i = `guess_d`i and `blank` = {4{!phase}}.
- Codes are passed through unmodified. Codes 0 and 7 are not filtered.
- Blink:
  - Counter runs 0..BLINK_DIV-1. Phase toggles when the counter wraps. phase = 1 means visible.
  - On every state entry, and on any change of `cursor` in EDIT, the counter is cleared to 0 and phase is set to 1. The cursor is therefore visible immediately after a move.
- Hold counter: cleared on entry to FEEDBACK, increments every cycle in FEEDBACK.
- Counter widths are `$clog2` of the respective parameter.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state EDIT, counters 0, phase 1, latched feedback 0.
  - `d0`..`d3` = 0, `blank` = 0, `showing_fb` = 0, `win` = 0.
  - `fb_ready` = 1 once `new_game` is low.
- `d`*, `blank`, `showing_fb` and `win` are registered. Each reflects the state and inputs sampled at the previous edge: one cycle of latency from a guess, cursor or state change.
- Feedback accepted at edge T:
  - state is FEEDBACK from T.
  - outputs show feedback and `showing_fb` = 1 after edge T+1.
  - state returns to EDIT at edge T+SHOW_CYCLES.
  - guess display resumes after edge T+SHOW_CYCLES+1.
- Back-to-back: `fb_ready` goes low in the cycle after acceptance, so a held `fb_valid` is not double-accepted. It is accepted again at the first edge after return to EDIT.
- Blink: with `edit_en` = 1 and the cursor stable, the cursor digit is blanked for BLINK_DIV cycles and then visible for BLINK_DIV cycles, repeating.
- Reset asserted mid-FEEDBACK or mid-WIN: immediate return to the reset values; no stale feedback remains on the display.

## Test plan
- Reset, then guesses 1,2,3,4, `edit_en` = 0 → one cycle later `d3..d0` = 4,3,2,1, `blank` = 0, `fb_ready` = 1.
- `BLINK_DIV` = 4, `edit_en` = 1, `cursor` = 2 → `blank` = 4'b0100 for 4 cycles, then 0 for 4 cycles, repeating.
  - Moving `cursor` to 0 mid-blank → `blank` = 0 for the next 4 cycles, then 4'b0001.
- `SHOW_CYCLES` = 10, pulse `fb_valid` with exact = 2, partial = 1 → `fb_ready` drops the next cycle.
  - Display shows `d3` = 2, `d2` = 1, `blank` = 4'b0011 for 10 cycles, then the guess returns.
  - A `fb_valid` held high throughout is accepted exactly twice: once at the start and once at the first edge after return to EDIT.
- `fb_valid` with exact = 4 → `win` = 1, all digits flash at BLINK_DIV and `fb_ready` stays 0.
  - `new_game` pulse → EDIT, `win` = 0.
- `new_game` and `fb_valid` in the same cycle in EDIT → feedback not accepted, `showing_fb` stays 0.
- `rst_n` dropped asynchronously mid-FEEDBACK → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/mm_display_scheduler.sv
// Display sequencer for the Mastermind seven-segment path: shares the four digits
// between the guess editor and the scoring unit, and drives cursor blink, timed feedback and win flash.
module mm_display_scheduler #(
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter int unsigned SHOW_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] guess_d0,
  input  logic [2:0] guess_d1,
  input  logic [2:0] guess_d2,
  input  logic [2:0] guess_d3,
  input  logic [1:0] cursor,
  input  logic       edit_en,
  input  logic       fb_valid,
  input  logic [2:0] fb_exact,
  input  logic [2:0] fb_partial,
  output logic       fb_ready,
  input  logic       new_game,
  output logic [2:0] d0,
  output logic [2:0] d1,
  output logic [2:0] d2,
  output logic [2:0] d3,
  output logic [3:0] blank,
  output logic       showing_fb,
  output logic       win
);

  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam int unsigned HW = $clog2(SHOW_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(SHOW_CYCLES - 1);

  typedef enum logic [1:0] {
    EDIT     = 2'd0,
    FEEDBACK = 2'd1,
    WIN      = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_blink_cnt;
  logic [BW-1:0] w_blink_cnt_nxt;
  logic          r_phase;
  logic          w_phase_nxt;
  logic [HW-1:0] r_hold;
  logic [2:0]    r_exact;
  logic [2:0]    r_partial;
  logic [1:0]    r_cursor_q;
  logic          w_accept;
  logic          w_restart;
  logic [2:0]    r_d0, r_d1, r_d2, r_d3;
  logic [3:0]    r_blank;
  logic          r_showing_fb;
  logic          r_win;
  logic [2:0]    w_d0, w_d1, w_d2, w_d3;
  logic [3:0]    w_blank;

  assign fb_ready = (r_state == EDIT) && !new_game;
  assign w_accept = fb_valid && fb_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (new_game) begin
      w_state_nxt = EDIT;
    end else begin
      unique case (r_state)
        EDIT:     if (w_accept) w_state_nxt = (fb_exact == 3'd4) ? WIN : FEEDBACK;
        FEEDBACK: if (r_hold == HOLD_LAST) w_state_nxt = EDIT;
        WIN:      w_state_nxt = WIN;
        default:  w_state_nxt = EDIT;
      endcase
    end
  end

  // Blink restarts visible on every state entry and on each cursor move while editing.
  assign w_restart = (w_state_nxt != r_state) ||
                     ((r_state == EDIT) && (cursor != r_cursor_q));

  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt + BW'(1);
    w_phase_nxt     = r_phase;
    if (w_restart) begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = !r_phase;
    end
  end

  // Blank uses the phase being registered this edge so a moved cursor shows at once.
  always_comb begin
    w_d0    = guess_d0;
    w_d1    = guess_d1;
    w_d2    = guess_d2;
    w_d3    = guess_d3;
    w_blank = '0;
    unique case (r_state)
      EDIT: begin
        if (edit_en && !w_phase_nxt) w_blank = 4'b0001 << cursor;
      end
      FEEDBACK: begin
        w_d3    = r_exact;
        w_d2    = r_partial;
        w_d1    = '0;
        w_d0    = '0;
        w_blank = 4'b0011;
      end
      WIN: begin
        w_blank = {4{!w_phase_nxt}};
      end
      default: w_blank = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= EDIT;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b1;
      r_hold       <= '0;
      r_exact      <= '0;
      r_partial    <= '0;
      r_cursor_q   <= '0;
      r_d0         <= '0;
      r_d1         <= '0;
      r_d2         <= '0;
      r_d3         <= '0;
      r_blank      <= '0;
      r_showing_fb <= 1'b0;
      r_win        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_cursor_q  <= cursor;
      if (r_state != FEEDBACK) r_hold <= '0;
      else                     r_hold <= r_hold + HW'(1);
      if (w_accept) begin
        r_exact   <= fb_exact;
        r_partial <= fb_partial;
      end
      r_d0         <= w_d0;
      r_d1         <= w_d1;
      r_d2         <= w_d2;
      r_d3         <= w_d3;
      r_blank      <= w_blank;
      r_showing_fb <= (r_state == FEEDBACK);
      r_win        <= (r_state == WIN);
    end
  end

  assign d0         = r_d0;
  assign d1         = r_d1;
  assign d2         = r_d2;
  assign d3         = r_d3;
  assign blank      = r_blank;
  assign showing_fb = r_showing_fb;
  assign win        = r_win;

endmodule

// File: tb/tb_mm_display_scheduler.sv
// Scoreboard bench for mm_display_scheduler: a cycle-level reference model queues the
// expected display per edge and an independent monitor pops and compares it.
module tb_mm_display_scheduler;

  localparam int B = 4;
  localparam int S = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] guess_d0, guess_d1, guess_d2, guess_d3;
  logic [1:0] cursor;
  logic       edit_en, fb_valid, new_game;
  logic [2:0] fb_exact, fb_partial;
  logic       fb_ready;
  logic [2:0] d0, d1, d2, d3;
  logic [3:0] blank;
  logic       showing_fb, win;

  mm_display_scheduler #(.BLINK_DIV(B), .SHOW_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .guess_d0(guess_d0), .guess_d1(guess_d1), .guess_d2(guess_d2), .guess_d3(guess_d3),
    .cursor(cursor), .edit_en(edit_en),
    .fb_valid(fb_valid), .fb_exact(fb_exact), .fb_partial(fb_partial), .fb_ready(fb_ready),
    .new_game(new_game),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .blank(blank), .showing_fb(showing_fb), .win(win)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    logic [3:0]  blank;
    logic        sfb;
    logic        win;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;
  int n_accept = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=edit, 1=feedback, 2=win; blink visibility from the age since restart.
  int          m_mode, m_left, m_age, nxt, nleft;
  logic [1:0]  m_prev_cur;
  logic [2:0]  m_exact, m_partial, nex, npa;
  logic        restart, vis;
  exp_t        e;

  initial begin
    m_mode = 0; m_left = 0; m_age = 0; m_prev_cur = '0; m_exact = '0; m_partial = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_mode = 0; m_left = 0; m_age = 0; m_prev_cur = '0; m_exact = '0; m_partial = '0;
      end else begin
        if (fb_valid && fb_ready) n_accept++;
        nxt = m_mode; nleft = m_left; nex = m_exact; npa = m_partial;
        if (new_game) begin
          nxt = 0;
        end else if (m_mode == 0 && fb_valid) begin
          nex = fb_exact; npa = fb_partial; nleft = S;
          nxt = (fb_exact == 3'd4) ? 2 : 1;
        end else if (m_mode == 1) begin
          nleft = m_left - 1;
          if (nleft == 0) nxt = 0;
        end
        restart = (nxt != m_mode) || (m_mode == 0 && cursor != m_prev_cur);
        m_age   = restart ? 0 : m_age + 1;
        vis     = ((m_age / B) % 2) == 0;
        e.d     = {guess_d3, guess_d2, guess_d1, guess_d0};
        e.blank = 4'b0000;
        if (m_mode == 0) begin
          if (edit_en && !vis) e.blank = 4'b0001 << cursor;
        end else if (m_mode == 1) begin
          e.d     = {m_exact, m_partial, 6'b000000};
          e.blank = 4'b0011;
        end else begin
          e.blank = vis ? 4'b0000 : 4'b1111;
        end
        e.sfb = (m_mode == 1);
        e.win = (m_mode == 2);
        e.rdy = (nxt == 0) && !new_game;
        q.push_back(e);
        n_push++;
        m_mode = nxt; m_left = nleft; m_exact = nex; m_partial = npa; m_prev_cur = cursor;
      end
    end
  end

  exp_t got;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        got = q.pop_front();
        n_pop++;
        chk("digits", {20'd0, d3, d2, d1, d0}, {20'd0, got.d});
        chk("blank", {28'd0, blank}, {28'd0, got.blank});
        chk("showing_fb", {31'd0, showing_fb}, {31'd0, got.sfb});
        chk("win", {31'd0, win}, {31'd0, got.win});
        chk("fb_ready", {31'd0, fb_ready}, {31'd0, got.rdy});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_digits"}, {20'd0, d3, d2, d1, d0}, 32'd0);
    chk({tag, "_blank"}, {28'd0, blank}, 32'd0);
    chk({tag, "_showing_fb"}, {31'd0, showing_fb}, 32'd0);
    chk({tag, "_win"}, {31'd0, win}, 32'd0);
    chk({tag, "_fb_ready"}, {31'd0, fb_ready}, 32'd1);
  endtask

  int acc_base;

  initial begin
    guess_d0 = 3'd0; guess_d1 = 3'd0; guess_d2 = 3'd0; guess_d3 = 3'd0;
    cursor = 2'd0; edit_en = 1'b0; fb_valid = 1'b0; new_game = 1'b0;
    fb_exact = 3'd0; fb_partial = 3'd0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    cycles(2);
    guess_d0 = 3'd1; guess_d1 = 3'd2; guess_d2 = 3'd3; guess_d3 = 3'd4;
    rst_n = 1'b1;
    cycles(3);

    // Cursor blink, then a move in the middle of a blanked half-period.
    edit_en = 1'b1; cursor = 2'd2;
    cycles(14);
    cursor = 2'd0;
    cycles(12);
    edit_en = 1'b0;

    // Single feedback pulse.
    fb_exact = 3'd2; fb_partial = 3'd1; fb_valid = 1'b1;
    cycles(1);
    fb_valid = 1'b0;
    cycles(14);

    // Held fb_valid: accepted at the start and again right after returning to EDIT.
    acc_base = n_accept;
    fb_exact = 3'd1; fb_partial = 3'd3; fb_valid = 1'b1;
    cycles(15);
    fb_valid = 1'b0;
    cycles(1);
    chk("held_valid_accepts", n_accept - acc_base, 32'd2);
    cycles(12);

    // Win flash, then new game.
    fb_exact = 3'd4; fb_partial = 3'd0; fb_valid = 1'b1;
    cycles(1);
    fb_valid = 1'b0;
    cycles(20);
    new_game = 1'b1;
    cycles(1);
    new_game = 1'b0;
    cycles(3);

    // new_game wins over feedback offered in the same cycle.
    fb_exact = 3'd3; fb_partial = 3'd1; fb_valid = 1'b1; new_game = 1'b1;
    cycles(1);
    fb_valid = 1'b0; new_game = 1'b0;
    cycles(4);

    for (int i = 0; i < 1500; i++) begin
      guess_d0 = 3'($urandom); guess_d1 = 3'($urandom);
      guess_d2 = 3'($urandom); guess_d3 = 3'($urandom);
      if ($urandom_range(7) == 0)  cursor = 2'($urandom);
      if ($urandom_range(31) == 0) edit_en = !edit_en;
      fb_valid   = ($urandom_range(5) == 0);
      fb_exact   = 3'($urandom_range(4));
      fb_partial = 3'($urandom_range(4));
      new_game   = ($urandom_range(39) == 0);
      cycles(1);
    end
    fb_valid = 1'b0; new_game = 1'b0;
    cycles(25);

    // Asynchronous reset in the middle of FEEDBACK.
    fb_exact = 3'd1; fb_partial = 3'd2; fb_valid = 1'b1;
    cycles(1);
    fb_valid = 1'b0;
    cycles(4);
    chk("pre_reset_showing_fb", {31'd0, showing_fb}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    cycles(2);
    rst_n = 1'b1;
    cycles(10);

    chk("scoreboard_drained", n_pop, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
